fetch_stall_unit: RTL

Fetch-side responder to the hazard detection unit of the 19-bit pipelined CPU. Owns the PC register and the IF/ID pipeline register and acts on the PCwrite / IF_IDwrite stall requests that the hazard unit raises on a load-use hazard. It also handles branch-taken redirects with a one-entry flush. A small state machine tracks fill, run, stall and flush phases, and flags control-protocol violations.

---
 rtl/fetch_stall_unit_if.sv | 37 +++
 rtl/fetch_stall_unit.sv | 104 ++++++++++
 2 files changed

// File: rtl/fetch_stall_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stall_unit_if
// Description : Hazard-control, fetch and IF/ID bundle for fetch_stall_unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_stall_unit_if #(
    parameter int PC_W    = 19,
    parameter int INSTR_W = 19
);
    logic               PCwrite;
    logic               IF_IDwrite;
    logic               branch_taken;
    logic [PC_W-1:0]    branch_target;
    logic [INSTR_W-1:0] imem_data;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] IF_ID_instr;
    logic [PC_W-1:0]    IF_ID_pc;
    logic               IF_ID_valid;
    logic               stalled;
    logic               ctrl_err;
    logic [15:0]        stall_cnt;
    logic [15:0]        flush_cnt;

    modport master (
        output PCwrite, IF_IDwrite, branch_taken, branch_target, imem_data,
        input  imem_addr, IF_ID_instr, IF_ID_pc, IF_ID_valid, stalled,
               ctrl_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  PCwrite, IF_IDwrite, branch_taken, branch_target, imem_data,
        output imem_addr, IF_ID_instr, IF_ID_pc, IF_ID_valid, stalled,
               ctrl_err, stall_cnt, flush_cnt
    );
endinterface
`default_nettype wire

// File: rtl/fetch_stall_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stall_unit
// Description : PC and IF/ID register owner reacting to load-use stalls and
//               branch-taken flushes. Define STALL_CNT_EN to build counters.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stall_unit #(
    parameter int                   PC_W      = 19,
    parameter int                   INSTR_W   = 19,
    parameter logic [PC_W-1:0]      RESET_PC  = '0,
    parameter logic [INSTR_W-1:0]   NOP_INSTR = '0
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    fetch_stall_unit_if.slave  bus
);
    localparam logic [1:0]      c_FILL   = 2'd0;
    localparam logic [1:0]      c_RUN    = 2'd1;
    localparam logic [1:0]      c_STALL  = 2'd2;
    localparam logic [1:0]      c_FLUSH  = 2'd3;
    localparam logic [PC_W-1:0] c_PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    logic [PC_W-1:0]    r_pc;
    logic [INSTR_W-1:0] r_instr;
    logic [PC_W-1:0]    r_if_pc;
    logic               r_valid;
    logic [1:0]         r_state;
    logic               r_ctrl_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_instr    <= NOP_INSTR;
            r_if_pc    <= '0;
            r_valid    <= 1'b0;
            r_state    <= c_FILL;
            r_ctrl_err <= 1'b0;
        end else begin
            if (bus.branch_taken) begin
                r_pc <= bus.branch_target;
            end else if (bus.PCwrite) begin
                r_pc <= r_pc + c_PC_ONE;
            end

            // Flush outranks any stall request from the hazard unit
            if (bus.branch_taken) begin
                r_instr <= NOP_INSTR;
                r_if_pc <= '0;
                r_valid <= 1'b0;
            end else if (bus.IF_IDwrite) begin
                r_instr <= bus.imem_data;
                r_if_pc <= r_pc;
                r_valid <= 1'b1;
            end

            if (bus.branch_taken) begin
                r_state <= c_FLUSH;
            end else if (!bus.IF_IDwrite) begin
                r_state <= c_STALL;
            end else begin
                r_state <= c_RUN;
            end

            if (!bus.branch_taken && (bus.PCwrite != bus.IF_IDwrite)) begin
                r_ctrl_err <= 1'b1;
            end
        end
    end

`ifdef STALL_CNT_EN
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= 16'd0;
            r_flush_cnt <= 16'd0;
        end else begin
            if (!bus.branch_taken && !bus.IF_IDwrite && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (bus.branch_taken && (r_flush_cnt != 16'hFFFF)) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
    assign bus.flush_cnt = r_flush_cnt;
`else
    assign bus.stall_cnt = 16'd0;
    assign bus.flush_cnt = 16'd0;
`endif

    assign bus.imem_addr   = r_pc;
    assign bus.IF_ID_instr = r_instr;
    assign bus.IF_ID_pc    = r_if_pc;
    assign bus.IF_ID_valid = r_valid;
    assign bus.stalled     = (r_state == c_STALL);
    assign bus.ctrl_err    = r_ctrl_err;

endmodule
`default_nettype wire
